pdm_boxcar_decimator: RTL and testbench

PDM_BOXCAR_DECIMATOR -- requirements
Module: pdm_boxcar_decimator

---
 rtl/pdm_boxcar_decimator.sv | 139 +++++++++++++
 tb/tb_pdm_boxcar_decimator.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_boxcar_decimator.sv
// Boxcar (ones-count) decimator for a NUM_ROWS x NUM_COLS PDM microphone array.
// Each completed block is copied to a shadow bank and streamed out one channel per beat.
module pdm_boxcar_decimator #(
  parameter int NUM_ROWS  = 5,
  parameter int NUM_COLS  = 8,
  parameter int DEC_WIDTH = 8,
  parameter int NUM_CH    = NUM_ROWS * NUM_COLS,
  parameter int CH_WIDTH  = $clog2(NUM_CH)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic                               sample_stb,
  input  logic [NUM_COLS-1:0][NUM_ROWS-1:0]  in_data,
  input  logic [DEC_WIDTH-1:0]               decim,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DEC_WIDTH-1:0]               out_data,
  output logic [CH_WIDTH-1:0]                out_chan,
  output logic                               out_sop,
  output logic                               out_eop,
  output logic                               overrun,
  input  logic                               clear_overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state, state_next;
  logic [CH_WIDTH-1:0]  idx, idx_next;

  logic [DEC_WIDTH-1:0] acc     [NUM_CH];
  logic [DEC_WIDTH-1:0] acc_sum [NUM_CH];
  logic [DEC_WIDTH-1:0] shadow  [NUM_CH];

  logic [DEC_WIDTH-1:0] frame_cnt, frame_cnt_inc, active_decim, eff_decim;
  logic                 shadow_full;
  logic                 stb_accept, block_done, beat_accept, last_beat;
  logic                 shadow_load, block_drop;

  // A block is open whenever frame_cnt is non-zero; only then is the latched length used.
  assign eff_decim     = (frame_cnt == '0) ? decim : active_decim;
  assign stb_accept    = enable && sample_stb && (eff_decim != '0);
  assign frame_cnt_inc = frame_cnt + DEC_WIDTH'(1);
  assign block_done    = stb_accept && (frame_cnt_inc == eff_decim);

  assign beat_accept   = (state == SEND) && out_ready;
  assign last_beat     = beat_accept && (idx == CH_WIDTH'(NUM_CH - 1));
  assign shadow_load   = block_done && (!shadow_full || last_beat);
  assign block_drop    = block_done && !shadow_load;

  always_comb begin
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        acc_sum[c*NUM_ROWS + r] = acc[c*NUM_ROWS + r] + DEC_WIDTH'(in_data[c][r]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt    <= '0;
      active_decim <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) acc[ch] <= '0;
    end else if (!enable) begin
      frame_cnt    <= '0;
      active_decim <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) acc[ch] <= '0;
    end else if (stb_accept) begin
      active_decim <= eff_decim;
      if (block_done) begin
        frame_cnt <= '0;
        for (int ch = 0; ch < NUM_CH; ch++) acc[ch] <= '0;
      end else begin
        frame_cnt <= frame_cnt_inc;
        for (int ch = 0; ch < NUM_CH; ch++) acc[ch] <= acc_sum[ch];
      end
    end
  end

  // NOTE: the shadow bank is plain storage with no reset; out_data is forced to zero
  // whenever out_valid is low, so its power-up contents are never visible.
  always_ff @(posedge clk) begin
    if (shadow_load) begin
      for (int ch = 0; ch < NUM_CH; ch++) shadow[ch] <= acc_sum[ch];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_full <= 1'b0;
      overrun     <= 1'b0;
      state       <= IDLE;
      idx         <= '0;
    end else begin
      if (shadow_load)    shadow_full <= 1'b1;
      else if (last_beat) shadow_full <= 1'b0;

      // A drop in the same cycle as a clear wins, so no overrun event is lost.
      if (block_drop)         overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;

      state <= state_next;
      idx   <= idx_next;
    end
  end

  // NOTE: every signal written here gets a default first so no latch can be inferred.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (shadow_full) begin
          state_next = SEND;
          idx_next   = '0;
        end
      end
      SEND: begin
        if (last_beat) begin
          idx_next   = '0;
          state_next = shadow_load ? SEND : IDLE;
        end else if (beat_accept) begin
          idx_next = idx + CH_WIDTH'(1);
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  assign out_valid = (state == SEND);
  assign out_data  = out_valid ? shadow[idx] : '0;
  assign out_chan  = idx;
  assign out_sop   = out_valid && (idx == '0);
  assign out_eop   = out_valid && (idx == CH_WIDTH'(NUM_CH - 1));

endmodule

// File: tb/tb_pdm_boxcar_decimator.sv
// Randomized bench for pdm_boxcar_decimator: a frame-list model computes per-channel
// ones-counts and a monitor scoreboards every accepted beat.
module tb_pdm_boxcar_decimator;

  localparam int NUM_ROWS  = 5;
  localparam int NUM_COLS  = 8;
  localparam int DEC_WIDTH = 8;
  localparam int NUM_CH    = NUM_ROWS * NUM_COLS;
  localparam int CH_WIDTH  = $clog2(NUM_CH);

  typedef logic [NUM_COLS-1:0][NUM_ROWS-1:0] frame_t;
  typedef struct packed {
    logic [CH_WIDTH-1:0]  chan;
    logic [DEC_WIDTH-1:0] data;
    logic                 sop;
    logic                 eop;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 reset_n, enable, sample_stb, clear_overrun;
  logic                 out_ready = 1'b0;
  frame_t               in_data;
  logic [DEC_WIDTH-1:0] decim, out_data;
  logic [CH_WIDTH-1:0]  out_chan;
  logic                 out_valid, out_sop, out_eop, overrun;

  int     pass_cnt  = 0;
  int     check_cnt = 0;
  int     ready_mode = 0;   // 0: hold ready_hold, 1: toggle, 2: random
  logic   ready_hold = 1'b1;
  beat_t  got_q[$];
  beat_t  exp_q[$];
  frame_t blk_q[$];
  beat_t  cur_beat, prev_beat;
  logic   prev_stall = 1'b0;

  always #5 clk = ~clk;

  pdm_boxcar_decimator dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .sample_stb    (sample_stb),
    .in_data       (in_data),
    .decim         (decim),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_chan      (out_chan),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = ready_hold;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Beat monitor plus stall-stability check on the opposite edge.
  always @(negedge clk) begin
    cur_beat = {out_chan, out_data, out_sop, out_eop};
    if (reset_n && prev_stall) begin
      check_cnt++;
      if (out_valid !== 1'b1 || cur_beat !== prev_beat)
        $display("FAIL stall_stable: got valid=%b beat=%h, required valid=1 beat=%h",
                 out_valid, cur_beat, prev_beat);
      else pass_cnt++;
    end
    if (reset_n && out_valid && out_ready) got_q.push_back(cur_beat);
    prev_stall = reset_n && out_valid && !out_ready;
    prev_beat  = cur_beat;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic frame_t rand_frame();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[NUM_CH-1:0];
  endfunction

  // Reference: channel c of a block is the count of ones at [c/NUM_ROWS][c%NUM_ROWS].
  function automatic void expect_block();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      int s;
      s = 0;
      foreach (blk_q[i]) s += int'(blk_q[i][ch / NUM_ROWS][ch % NUM_ROWS]);
      exp_q.push_back({CH_WIDTH'(ch), DEC_WIDTH'(s), ch == 0, ch == NUM_CH - 1});
    end
    blk_q.delete();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    in_data = rand_frame();
  endtask

  task automatic gap(int max_idle);
    repeat ($urandom_range(0, max_idle)) step();
  endtask

  task automatic strobe(frame_t f, bit record);
    sample_stb = 1'b1;
    in_data    = f;
    @(posedge clk);
    #1;
    sample_stb = 1'b0;
    in_data    = rand_frame();
    if (record) blk_q.push_back(f);
  endtask

  task automatic clear_path();
    enable = 1'b0;
    step();
    enable = 1'b1;
  endtask

  task automatic wait_beats(string name, int n);
    int budget;
    budget = 3000;
    while (got_q.size() < n && budget > 0) begin
      step();
      budget--;
    end
    repeat (8) step();
    check_cnt++;
    if (budget == 0) $display("FAIL %s_timeout: got %0d beats, required %0d", name, got_q.size(), n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; sample_stb = 1'b0; clear_overrun = 1'b0;
    decim = 8'd4; in_data = '0; ready_mode = 0; ready_hold = 1'b1;
    repeat (2) strobe('1, 0);
    #2;
    check_cnt++;
    if ({out_valid, out_sop, out_eop, overrun} !== 4'b0)
      $display("FAIL reset_flags: got %b, required 0000", {out_valid, out_sop, out_eop, overrun});
    else pass_cnt++;
    check_cnt++;
    if (out_data !== '0) $display("FAIL reset_data: got %0d, required 0", out_data);
    else pass_cnt++;
    check_cnt++;
    if (out_chan !== '0) $display("FAIL reset_chan: got %0d, required 0", out_chan);
    else pass_cnt++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (5) step();
    check_cnt++;
    if (out_valid !== 1'b0 || got_q.size() != 0)
      $display("FAIL reset_release_idle: got valid=%b beats=%0d, required 0/0", out_valid, got_q.size());
    else pass_cnt++;
  endtask

  task automatic test_all_ones();
    int lat;
    got_q.delete(); exp_q.delete(); blk_q.delete();
    ready_mode = 0; ready_hold = 1'b1; decim = 8'd4;
    clear_path();
    for (int i = 0; i < 4; i++) begin
      gap(2);
      strobe('1, 1);
    end
    expect_block();
    lat = 0;
    while (out_valid !== 1'b1 && lat < 3) begin step(); lat++; end
    check_cnt++;
    if (lat > 2) $display("FAIL all_ones_latency: got >%0d clocks, required <= 2", lat - 1);
    else pass_cnt++;
    wait_beats("all_ones", exp_q.size());
    check_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL all_ones_count: got %0d, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) begin
      check_cnt++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i])
        $display("FAIL all_ones_beat%0d: got %h, required %h", i, (got_q.size() > i) ? got_q[i] : beat_t'('0), exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_single_mic();
    frame_t f;
    got_q.delete(); exp_q.delete(); blk_q.delete();
    ready_mode = 2; decim = 8'd3;
    f = '0;
    f[2][1] = 1'b1;
    for (int i = 0; i < 3; i++) begin gap(3); strobe(f, 1); end
    expect_block();
    wait_beats("single_mic", exp_q.size());
    check_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL single_mic_count: got %0d, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) begin
      check_cnt++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i])
        $display("FAIL single_mic_beat%0d: got %h, required %h", i, (got_q.size() > i) ? got_q[i] : beat_t'('0), exp_q[i]);
      else pass_cnt++;
    end
  endtask

  // Random block lengths; decim is scrambled (including 0) after each block's first strobe.
  task automatic test_random_blocks();
    int d;
    got_q.delete(); exp_q.delete(); blk_q.delete();
    ready_mode = 2;
    for (int b = 0; b < 5; b++) begin
      d = $urandom_range(1, 7);
      decim = DEC_WIDTH'(d);
      for (int i = 0; i < d; i++) begin
        gap(2);
        strobe(rand_frame(), 1);
        if (i == 0) decim = DEC_WIDTH'($urandom_range(0, 9));
      end
      expect_block();
      wait_beats("random_blocks", exp_q.size());
    end
    check_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL random_blocks_count: got %0d, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) begin
      check_cnt++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i])
        $display("FAIL random_blocks_beat%0d: got %h, required %h", i, (got_q.size() > i) ? got_q[i] : beat_t'('0), exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_decim_change();
    got_q.delete(); exp_q.delete(); blk_q.delete();
    ready_mode = 0; ready_hold = 1'b1; decim = 8'd2;
    clear_path();
    strobe(rand_frame(), 1);
    decim = 8'd5;
    gap(2);
    strobe(rand_frame(), 1);
    expect_block();
    wait_beats("decim_change_first", exp_q.size());
    for (int i = 0; i < 4; i++) begin
      gap(2);
      strobe(rand_frame(), 1);
      if (i == 0) decim = 8'd2;
    end
    repeat (4) step();
    check_cnt++;
    if (out_valid !== 1'b0 || got_q.size() != NUM_CH)
      $display("FAIL decim_change_early: got valid=%b beats=%0d, required 0/%0d", out_valid, got_q.size(), NUM_CH);
    else pass_cnt++;
    strobe(rand_frame(), 1);
    expect_block();
    wait_beats("decim_change_second", exp_q.size());
    check_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL decim_change_count: got %0d, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) begin
      check_cnt++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i])
        $display("FAIL decim_change_beat%0d: got %h, required %h", i, (got_q.size() > i) ? got_q[i] : beat_t'('0), exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_toggle_ready();
    int d;
    got_q.delete(); exp_q.delete(); blk_q.delete();
    ready_mode = 1;
    d = $urandom_range(1, 4);
    decim = DEC_WIDTH'(d);
    for (int i = 0; i < d; i++) begin gap(1); strobe(rand_frame(), 1); end
    expect_block();
    wait_beats("toggle_ready", exp_q.size());
    check_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL toggle_ready_count: got %0d, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) begin
      check_cnt++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i])
        $display("FAIL toggle_ready_beat%0d: got %h, required %h", i, (got_q.size() > i) ? got_q[i] : beat_t'('0), exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_overrun();
    got_q.delete(); exp_q.delete(); blk_q.delete();
    ready_mode = 0; ready_hold = 1'b0; decim = 8'd2;
    clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
    check_cnt++;
    if (overrun !== 1'b0) $display("FAIL overrun_initial: got %b, required 0", overrun);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin gap(1); strobe(rand_frame(), 1); end
    expect_block();
    for (int i = 0; i < 2; i++) begin gap(1); strobe(rand_frame(), 0); end
    repeat (3) step();
    check_cnt++;
    if (out_valid !== 1'b1 || out_chan !== '0 || out_data !== exp_q[0].data || out_sop !== 1'b1)
      $display("FAIL overrun_hold: got valid=%b chan=%0d data=%0d sop=%b, required 1/0/%0d/1",
               out_valid, out_chan, out_data, out_sop, exp_q[0].data);
    else pass_cnt++;
    check_cnt++;
    if (overrun !== 1'b1) $display("FAIL overrun_set: got %b, required 1", overrun);
    else pass_cnt++;
    decim = 8'd1;
    clear_overrun = 1'b1;
    strobe(rand_frame(), 0);
    clear_overrun = 1'b0;
    check_cnt++;
    if (overrun !== 1'b1) $display("FAIL overrun_clear_race: got %b, required 1", overrun);
    else pass_cnt++;
    clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
    check_cnt++;
    if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b, required 0", overrun);
    else pass_cnt++;
    ready_hold = 1'b1;
    wait_beats("overrun", exp_q.size());
    check_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL overrun_count: got %0d, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) begin
      check_cnt++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i])
        $display("FAIL overrun_beat%0d: got %h, required %h", i, (got_q.size() > i) ? got_q[i] : beat_t'('0), exp_q[i]);
      else pass_cnt++;
    end
  endtask

  // Second block completes on the very edge that accepts the first block's last beat.
  task automatic test_back_to_back();
    int budget;
    got_q.delete(); exp_q.delete(); blk_q.delete();
    ready_mode = 0; ready_hold = 1'b1; decim = 8'd1;
    strobe(rand_frame(), 1);
    expect_block();
    budget = 200;
    do begin @(negedge clk); budget--; end
    while (!(out_valid === 1'b1 && out_chan == CH_WIDTH'(NUM_CH - 1)) && budget > 0);
    check_cnt++;
    if (budget == 0) $display("FAIL back_to_back_eop_timeout: got no eop beat, required one");
    else pass_cnt++;
    strobe(rand_frame(), 1);
    expect_block();
    wait_beats("back_to_back", exp_q.size());
    check_cnt++;
    if (overrun !== 1'b0) $display("FAIL back_to_back_overrun: got %b, required 0", overrun);
    else pass_cnt++;
    check_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL back_to_back_count: got %0d, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) begin
      check_cnt++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i])
        $display("FAIL back_to_back_beat%0d: got %h, required %h", i, (got_q.size() > i) ? got_q[i] : beat_t'('0), exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_enable_clear();
    got_q.delete(); exp_q.delete(); blk_q.delete();
    ready_mode = 2; decim = 8'd3;
    strobe(rand_frame(), 0);
    enable = 1'b0;
    strobe('1, 0);
    enable = 1'b1;
    decim = 8'd0;
    repeat (3) strobe('1, 0);
    repeat (4) step();
    check_cnt++;
    if (out_valid !== 1'b0 || got_q.size() != 0)
      $display("FAIL enable_clear_idle: got valid=%b beats=%0d, required 0/0", out_valid, got_q.size());
    else pass_cnt++;
    decim = 8'd3;
    for (int i = 0; i < 3; i++) begin gap(2); strobe(rand_frame(), 1); end
    enable = 1'b0;
    expect_block();
    wait_beats("enable_clear", exp_q.size());
    enable = 1'b1;
    check_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL enable_clear_count: got %0d, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) begin
      check_cnt++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i])
        $display("FAIL enable_clear_beat%0d: got %h, required %h", i, (got_q.size() > i) ? got_q[i] : beat_t'('0), exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_send();
    int budget;
    got_q.delete(); exp_q.delete(); blk_q.delete();
    ready_mode = 0; ready_hold = 1'b1; decim = 8'd2;
    for (int i = 0; i < 2; i++) strobe(rand_frame(), 1);
    blk_q.delete();
    budget = 200;
    do begin @(negedge clk); budget--; end
    while (!(out_valid === 1'b1 && out_chan == CH_WIDTH'(17)) && budget > 0);
    check_cnt++;
    if (budget == 0) $display("FAIL reset_mid_send_chan17_timeout: got no chan 17 beat, required one");
    else pass_cnt++;
    #1 reset_n = 1'b0;
    #1;
    check_cnt++;
    if ({out_valid, out_sop, out_eop, overrun} !== 4'b0 || out_data !== '0 || out_chan !== '0)
      $display("FAIL reset_mid_send_outputs: got valid=%b sop=%b eop=%b ovr=%b data=%0d chan=%0d, required all 0",
               out_valid, out_sop, out_eop, overrun, out_data, out_chan);
    else pass_cnt++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    got_q.delete();
    decim = 8'd3;
    for (int i = 0; i < 3; i++) begin gap(2); strobe(rand_frame(), 1); end
    expect_block();
    wait_beats("reset_mid_send", exp_q.size());
    check_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL reset_mid_send_count: got %0d, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) begin
      check_cnt++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i])
        $display("FAIL reset_mid_send_beat%0d: got %h, required %h", i, (got_q.size() > i) ? got_q[i] : beat_t'('0), exp_q[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_single_mic();
    test_random_blocks();
    test_decim_change();
    test_toggle_ready();
    test_overrun();
    test_back_to_back();
    test_enable_clear();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
